seq_divider: RTL and testbench

Parametrised multi-cycle restoring divider for the ALU datapath, replacing the fixed 8-bit unsigned divider. It handles WIDTH-bit operands in unsigned or two's-complement signed mode and resolves one quotient bit per clock. It flags divide-by-zero and signed overflow, and signals completion to the ALU control FSM with a one-cycle done pulse.

---
 rtl/seq_divider.sv | 148 ++++++++++++++
 tb/tb_seq_divider.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, unsigned or two's-complement
// signed operands, with divide-by-zero and signed-overflow fast paths resolved at accept.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             error,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] count;
    logic             sign_q;
    logic             sign_r;

    logic             div_zero;
    logic             sgn_ovf;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // |MIN| is 1<<(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic           is_signed);
        return (is_signed && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    assign div_zero = (divisor == '0);
    assign sgn_ovf  = signed_mode && (dividend == MIN_VAL) && (divisor == '1);
    assign busy     = (state != IDLE);

    // Shift the next dividend bit into the partial remainder and try the subtraction.
    assign trial = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
    assign fits  = (trial >= {1'b0, d});
    assign diff  = trial - {1'b0, d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !div_zero && !sgn_ovf) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (count == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (div_zero) begin
                            quotient  <= '0;
                            remainder <= dividend;
                            error     <= 1'b1;
                            overflow  <= 1'b0;
                            done      <= 1'b1;
                        end else if (sgn_ovf) begin
                            quotient  <= dividend;
                            remainder <= '0;
                            error     <= 1'b0;
                            overflow  <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            d        <= magnitude(divisor, signed_mode);
                            q        <= magnitude(dividend, signed_mode);
                            r        <= '0;
                            count    <= '0;
                            sign_q   <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            sign_r   <= signed_mode & dividend[WIDTH-1];
                            error    <= 1'b0;
                            overflow <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r     <= fits ? diff : trial;
                    q     <= {q[WIDTH-2:0], fits};
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    quotient  <= sign_q ? negate(q) : q;
                    remainder <= sign_r ? negate(r[WIDTH-1:0]) : r[WIDTH-1:0];
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: WIDTH=16 main instance plus a WIDTH=8 instance.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, signed_mode;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, error, overflow;
    logic [W-1:0] quotient, remainder;

    logic         start8, signed_mode8;
    logic [7:0]   dividend8, divisor8;
    logic         busy8, done8, error8, overflow8;
    logic [7:0]   quotient8, remainder8;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .busy(busy), .quotient(quotient),
        .remainder(remainder), .done(done), .error(error), .overflow(overflow)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(signed_mode8),
        .dividend(dividend8), .divisor(divisor8), .busy(busy8), .quotient(quotient8),
        .remainder(remainder8), .done(done8), .error(error8), .overflow(overflow8)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        logic         ovf;
    } exp_t;

    typedef struct {
        bit           sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           err;
        bit           ovf;
        int           lat;
        int           bsy;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] sa, sb;
        e  = '0;
        sa = a;
        sb = b;
        if (b == '0) begin
            e.r   = a;
            e.err = 1'b1;
        end else if (sm && a == 16'h8000 && b == 16'hFFFF) begin
            e.q   = a;
            e.ovf = 1'b1;
        end else if (sm) begin
            e.q = sa / sb;
            e.r = sa % sb;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Drive one start pulse, record the expectation, then scramble inputs while busy.
    task automatic issue(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        start       = 1'b1;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start       = 1'b0;
        signed_mode = 1'($urandom);
        dividend    = W'($urandom);
        divisor     = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output int bsy, output bit ok);
        lat = 0;
        bsy = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bsy++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        start8 = 1'b0; signed_mode8 = 1'b0; dividend8 = '0; divisor8 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, overflow, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b err=%b ovf=%b q=%h r=%h, expected all 0",
                     busy, done, error, overflow, quotient, remainder);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        vec_t t[3];
        exp_t e;
        int lat, bsy;
        bit ok;
        t[0] = '{1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 17, 17};
        t[1] = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 17, 17};
        t[2] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 17};
        for (int i = 0; i < 3; i++) begin
            issue(t[i].sm, t[i].a, t[i].b, '{t[i].q, t[i].r, t[i].err, t[i].ovf});
            wait_done(lat, bsy, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {quotient, remainder, error, overflow} !== {e.q, e.r, e.err, e.ovf}) begin
                errors++;
                $display("FAIL unsigned[%0d] got done=%b q=%h r=%h err=%b ovf=%b, expected q=%h r=%h err=%b ovf=%b",
                         i, ok, quotient, remainder, error, overflow, e.q, e.r, e.err, e.ovf);
            end
            checks++;
            if (lat !== t[i].lat || bsy !== t[i].bsy) begin
                errors++;
                $display("FAIL unsigned_timing[%0d] got latency=%0d busy_cycles=%0d, expected %0d/%0d",
                         i, lat, bsy, t[i].lat, t[i].bsy);
            end
        end
    endtask

    task automatic test_signed();
        vec_t t[4];
        exp_t e;
        int lat, bsy;
        bit ok;
        t[0] = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17, 17};
        t[1] = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17, 17};
        t[2] = '{1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 1'b0, 17, 17};
        t[3] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            issue(t[i].sm, t[i].a, t[i].b, '{t[i].q, t[i].r, t[i].err, t[i].ovf});
            wait_done(lat, bsy, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {quotient, remainder, error, overflow} !== {e.q, e.r, e.err, e.ovf}) begin
                errors++;
                $display("FAIL signed[%0d] got done=%b q=%h r=%h err=%b ovf=%b, expected q=%h r=%h err=%b ovf=%b",
                         i, ok, quotient, remainder, error, overflow, e.q, e.r, e.err, e.ovf);
            end
            checks++;
            if (lat !== t[i].lat || bsy !== t[i].bsy) begin
                errors++;
                $display("FAIL signed_timing[%0d] got latency=%0d busy_cycles=%0d, expected %0d/%0d",
                         i, lat, bsy, t[i].lat, t[i].bsy);
            end
        end
    endtask

    task automatic test_div_zero();
        vec_t t[3];
        exp_t e;
        int lat, bsy;
        bit ok;
        t[0] = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0, 0, 0};
        t[1] = '{1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0, 0, 0};
        t[2] = '{1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 17, 17};
        for (int i = 0; i < 3; i++) begin
            issue(t[i].sm, t[i].a, t[i].b, '{t[i].q, t[i].r, t[i].err, t[i].ovf});
            wait_done(lat, bsy, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {quotient, remainder, error, overflow} !== {e.q, e.r, e.err, e.ovf}) begin
                errors++;
                $display("FAIL div_zero[%0d] got done=%b q=%h r=%h err=%b ovf=%b, expected q=%h r=%h err=%b ovf=%b",
                         i, ok, quotient, remainder, error, overflow, e.q, e.r, e.err, e.ovf);
            end
            checks++;
            if (lat !== t[i].lat || bsy !== t[i].bsy) begin
                errors++;
                $display("FAIL div_zero_timing[%0d] got latency=%0d busy_cycles=%0d, expected %0d/%0d",
                         i, lat, bsy, t[i].lat, t[i].bsy);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat, bsy;
        bit ok;
        issue(1'b0, 16'd1000, 16'd7, '{16'd142, 16'd6, 1'b0, 1'b0});
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; dividend = 16'd5; divisor = 16'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bsy, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {quotient, remainder, error, overflow} !== {e.q, e.r, e.err, e.ovf}) begin
            errors++;
            $display("FAIL ignored_start got done=%b q=%h r=%h, expected q=%h r=%h", ok, quotient, remainder, e.q, e.r);
        end
        // Launch the second division in the done cycle itself.
        start = 1'b1; signed_mode = 1'b1; dividend = 16'hFFF9; divisor = 16'h0002;
        exp_q.push_back(model(1'b1, 16'hFFF9, 16'h0002));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bsy, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || lat !== 17 || {quotient, remainder, error, overflow} !== {e.q, e.r, e.err, e.ovf}) begin
            errors++;
            $display("FAIL back_to_back got done=%b lat=%0d q=%h r=%h, expected lat=17 q=%h r=%h",
                     ok, lat, quotient, remainder, e.q, e.r);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || {quotient, remainder} !== {e.q, e.r}) begin
            errors++;
            $display("FAIL hold got done=%b q=%h r=%h, expected done=0 q=%h r=%h", done, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int lat, bsy;
        bit ok;
        int seen;
        issue(1'b0, 16'd1000, 16'd7, '{16'd142, 16'd6, 1'b0, 1'b0});
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, error, overflow, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got busy=%b done=%b q=%h r=%h, expected all 0", busy, done, quotient, remainder);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d active cycles, expected 0", seen);
        end
        issue(1'b0, 16'hFFFF, 16'h0001, model(1'b0, 16'hFFFF, 16'h0001));
        wait_done(lat, bsy, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {quotient, remainder, error, overflow} !== {e.q, e.r, e.err, e.ovf}) begin
            errors++;
            $display("FAIL after_abort got done=%b q=%h r=%h, expected q=%h r=%h", ok, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int lat, bsy;
        bit ok;
        bit sm;
        logic [W-1:0] a, b;
        for (int i = 0; i < 20; i++) begin
            sm = 1'($urandom);
            a  = W'($urandom);
            b  = (i % 7 == 3) ? '0 : W'($urandom_range(0, 3) == 0 ? $urandom_range(1, 20) : $urandom);
            issue(sm, a, b, model(sm, a, b));
            wait_done(lat, bsy, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {quotient, remainder, error, overflow} !== {e.q, e.r, e.err, e.ovf}) begin
                errors++;
                $display("FAIL random[%0d] sm=%b %h/%h got q=%h r=%h err=%b ovf=%b, expected q=%h r=%h err=%b ovf=%b",
                         i, sm, a, b, quotient, remainder, error, overflow, e.q, e.r, e.err, e.ovf);
            end
        end
    endtask

    task automatic test_width8();
        int lat;
        bit ok;
        @(negedge clk);
        start8 = 1'b1; signed_mode8 = 1'b0; dividend8 = 8'd200; divisor8 = 8'd13;
        @(posedge clk);
        #1 start8 = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        checks++;
        if (!ok || lat !== 9 || quotient8 !== 8'd15 || remainder8 !== 8'd5 || error8 !== 1'b0) begin
            errors++;
            $display("FAIL width8 got done=%b lat=%0d q=%0d r=%0d err=%b, expected lat=9 q=15 r=5 err=0",
                     ok, lat, quotient8, remainder8, error8);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_width8();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
